// File: rtl/dram_port_arbiter_pkg.sv
// rtl/dram_port_arbiter_pkg.sv - shared state encodings and port indices for the DRAM port arbiter
package dram_port_arbiter_pkg;

  typedef enum logic {
    ARB_WAIT_CALIB = 1'b0,
    ARB_RUN        = 1'b1
  } arb_state_t;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

endpackage

// File: rtl/SyncFIFO.sv
// rtl/SyncFIFO.sv - synchronous FIFO with registered full/empty flags and show-ahead read data
module SyncFIFO #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  w_push;
  logic                  w_pop;

  // Overflow and underflow requests are dropped so the pointers never wrap past each other.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;
  assign o_data = r_mem[r_rptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (ADDR_WIDTH+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ADDR_WIDTH'(1);
      end
      r_count <= w_count_next;
      o_full  <= (w_count_next == DEPTH_CNT);
      o_empty <= (w_count_next == '0);
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter of two cache ports onto one DRAM user interface
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int TAG_ADDR_WIDTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_p0_ren,
  input  logic                      i_p1_ren,
  input  logic                      i_p0_wen,
  input  logic                      i_p1_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_p0_addr,
  input  logic [APP_ADDR_WIDTH-2:0] i_p1_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_p0_data,
  input  logic [APP_DATA_WIDTH-1:0] i_p1_data,
  input  logic [APP_MASK_WIDTH-1:0] i_p0_mask,
  input  logic [APP_MASK_WIDTH-1:0] i_p1_mask,
  output logic                      o_p0_ack,
  output logic                      o_p1_ack,
  output logic [APP_DATA_WIDTH-1:0] o_p0_data,
  output logic [APP_DATA_WIDTH-1:0] o_p1_data,
  output logic                      o_p0_data_valid,
  output logic                      o_p1_data_valid,
  output logic                      o_dram_ren,
  output logic                      o_dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] o_dram_addr,
  output logic [APP_DATA_WIDTH-1:0] o_dram_data,
  output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
  input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
  input  logic                      i_dram_data_valid,
  input  logic                      i_dram_busy,
  input  logic                      i_dram_calib_done,
  output logic                      o_err
);

  arb_state_t r_state;
  logic       r_last;

  logic w_run;
  logic w_p0_elig;
  logic w_p1_elig;
  logic w_gnt0;
  logic w_gnt1;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_owner;
  logic w_pop;
  logic w_rw_err;

  // Reset also masks grants so nothing reaches DRAM while the tag FIFO is being cleared.
  assign w_run = (r_state == ARB_RUN) & ~i_rst;

  assign w_p0_elig = (i_p0_ren | i_p0_wen) & w_run & ~i_dram_busy & ~(i_p0_ren & w_fifo_full);
  assign w_p1_elig = (i_p1_ren | i_p1_wen) & w_run & ~i_dram_busy & ~(i_p1_ren & w_fifo_full);

  assign w_gnt0 = w_p0_elig & (~w_p1_elig | (r_last == PORT_DMEM));
  assign w_gnt1 = w_p1_elig & (~w_p0_elig | (r_last == PORT_IMEM));

  assign o_p0_ack = w_gnt0;
  assign o_p1_ack = w_gnt1;

  // A port raising ren and wen together is served as a read; the write half is dropped.
  assign o_dram_ren  = (w_gnt0 & i_p0_ren) | (w_gnt1 & i_p1_ren);
  assign o_dram_wen  = (w_gnt0 & i_p0_wen & ~i_p0_ren) | (w_gnt1 & i_p1_wen & ~i_p1_ren);
  assign o_dram_addr = w_gnt1 ? i_p1_addr : (w_gnt0 ? i_p0_addr : '0);
  assign o_dram_data = w_gnt1 ? i_p1_data : (w_gnt0 ? i_p0_data : '0);
  assign o_dram_mask = w_gnt1 ? i_p1_mask : (w_gnt0 ? i_p0_mask : '0);

  assign w_pop    = i_dram_data_valid & ~w_fifo_empty;
  assign w_rw_err = (w_p0_elig & i_p0_ren & i_p0_wen) | (w_p1_elig & i_p1_ren & i_p1_wen);

  SyncFIFO #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (TAG_ADDR_WIDTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (o_dram_ren),
    .i_data  (w_gnt1),
    .i_pop   (w_pop),
    .o_data  (w_owner),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ARB_WAIT_CALIB;
      r_last          <= PORT_DMEM;
      o_err           <= 1'b0;
      o_p0_data_valid <= 1'b0;
      o_p1_data_valid <= 1'b0;
      o_p0_data       <= '0;
      o_p1_data       <= '0;
    end else begin
      case (r_state)
        ARB_WAIT_CALIB: if (i_dram_calib_done) r_state <= ARB_RUN;
        ARB_RUN:        r_state <= ARB_RUN;
        default:        r_state <= ARB_WAIT_CALIB;
      endcase
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      if (w_rw_err || (i_dram_data_valid && w_fifo_empty)) begin
        o_err <= 1'b1;
      end
      o_p0_data_valid <= w_pop & (w_owner == PORT_IMEM);
      o_p1_data_valid <= w_pop & (w_owner == PORT_DMEM);
      if (w_pop && (w_owner == PORT_IMEM)) o_p0_data <= i_dram_data;
      if (w_pop && (w_owner == PORT_DMEM)) o_p1_data <= i_dram_data;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed table-driven bench for the DRAM port arbiter
module tb_dram_port_arbiter;

  logic         clk;
  logic         i_rst;
  logic         p0_ren, p1_ren, p0_wen, p1_wen;
  logic [26:0]  p0_addr, p1_addr;
  logic [127:0] p0_wdata, p1_wdata;
  logic [15:0]  p0_mask, p1_mask;
  logic         p0_ack, p1_ack;
  logic [127:0] p0_rdata, p1_rdata;
  logic         p0_valid, p1_valid;
  logic         dram_ren, dram_wen;
  logic [26:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [15:0]  dram_mask;
  logic [127:0] dram_rdata;
  logic         dram_dv, dram_busy, dram_calib;
  logic         err;

  int checks;
  int errors;

  dram_port_arbiter dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_p0_ren          (p0_ren),
    .i_p1_ren          (p1_ren),
    .i_p0_wen          (p0_wen),
    .i_p1_wen          (p1_wen),
    .i_p0_addr         (p0_addr),
    .i_p1_addr         (p1_addr),
    .i_p0_data         (p0_wdata),
    .i_p1_data         (p1_wdata),
    .i_p0_mask         (p0_mask),
    .i_p1_mask         (p1_mask),
    .o_p0_ack          (p0_ack),
    .o_p1_ack          (p1_ack),
    .o_p0_data         (p0_rdata),
    .o_p1_data         (p1_rdata),
    .o_p0_data_valid   (p0_valid),
    .o_p1_data_valid   (p1_valid),
    .o_dram_ren        (dram_ren),
    .o_dram_wen        (dram_wen),
    .o_dram_addr       (dram_addr),
    .o_dram_data       (dram_wdata),
    .o_dram_mask       (dram_mask),
    .i_dram_data       (dram_rdata),
    .i_dram_data_valid (dram_dv),
    .i_dram_busy       (dram_busy),
    .i_dram_calib_done (dram_calib),
    .o_err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0, r1, w1, busy, dv;
    logic        a0, a1, dren, dwen;
    logic [26:0] addr;
    logic [15:0] mask;
    logic        pv0, pv1;
  } vec_t;

  vec_t vt [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  localparam logic [127:0] LINE_D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LINE_A  = 128'hAAAA_0000_AAAA_0001_AAAA_0002_AAAA_0003;
  localparam logic [127:0] LINE_B  = 128'hBBBB_0000_BBBB_0001_BBBB_0002_BBBB_0003;

  initial begin
    checks = 0;
    errors = 0;
    // r0 w0 r1 w1 busy dv | a0 a1 dren dwen addr mask | pv0 pv1
    vt[0]  = '{1,0,1,0,0,0, 1,0,1,0, 27'h100, 16'h000F, 0,0};
    vt[1]  = '{1,0,1,0,0,1, 0,1,1,0, 27'h200, 16'hFFF0, 0,0};
    vt[2]  = '{1,0,1,0,0,1, 1,0,1,0, 27'h100, 16'h000F, 1,0};
    vt[3]  = '{1,0,1,0,0,1, 0,1,1,0, 27'h200, 16'hFFF0, 0,1};
    vt[4]  = '{0,0,0,0,0,1, 0,0,0,0, 27'h000, 16'h0000, 1,0};
    vt[5]  = '{0,0,0,0,0,0, 0,0,0,0, 27'h000, 16'h0000, 0,1};
    vt[6]  = '{0,0,0,1,1,0, 0,0,0,0, 27'h000, 16'h0000, 0,0};
    vt[7]  = '{0,0,0,1,1,0, 0,0,0,0, 27'h000, 16'h0000, 0,0};
    vt[8]  = '{0,0,0,1,0,0, 0,1,0,1, 27'h200, 16'hFFF0, 0,0};
    vt[9]  = '{0,0,0,0,0,0, 0,0,0,0, 27'h000, 16'h0000, 0,0};
    vt[10] = '{0,1,0,1,0,0, 1,0,0,1, 27'h100, 16'h000F, 0,0};
    vt[11] = '{0,1,0,1,0,0, 0,1,0,1, 27'h200, 16'hFFF0, 0,0};
    vt[12] = '{1,0,0,1,0,0, 1,0,1,0, 27'h100, 16'h000F, 0,0};
    vt[13] = '{1,0,0,1,0,1, 0,1,0,1, 27'h200, 16'hFFF0, 0,0};
    vt[14] = '{0,0,0,0,0,0, 0,0,0,0, 27'h000, 16'h0000, 1,0};

    p0_ren = 0; p1_ren = 0; p0_wen = 0; p1_wen = 0;
    p0_addr = 27'h100; p1_addr = 27'h200;
    p0_wdata = 128'h0F0F; p1_wdata = 128'hF0F0;
    p0_mask = 16'h000F; p1_mask = 16'hFFF0;
    dram_rdata = '0; dram_dv = 0; dram_busy = 0; dram_calib = 0;
    i_rst = 1;
    tick();
    tick();
    chk("rst_err", err, 0);
    chk("rst_pv0", p0_valid, 0);
    chk("rst_pv1", p1_valid, 0);
    chk("rst_p0_data", p0_rdata, 0);
    chk("rst_p1_data", p1_rdata, 0);
    chk("rst_dram_ren", dram_ren, 0);
    chk("rst_dram_wen", dram_wen, 0);
    i_rst = 0;

    // calibration gating with a pending read
    p0_ren = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("calib_ack0", p0_ack, 0);
      chk("calib_dren", dram_ren, 0);
      tick();
    end
    dram_calib = 1;
    #1 chk("calib_rise_ack0", p0_ack, 0);
    tick();
    #1;
    chk("calib_run_ack0", p0_ack, 1);
    chk("calib_run_dren", dram_ren, 1);
    chk("calib_run_addr", dram_addr, 27'h100);
    tick();
    p0_ren = 0;
    dram_dv = 1; dram_rdata = LINE_D1;
    tick();
    dram_dv = 0;
    #1;
    chk("calib_resp_pv0", p0_valid, 1);
    chk("calib_resp_data", p0_rdata, LINE_D1);
    chk("calib_resp_pv1", p1_valid, 0);
    tick();
    #1 chk("calib_resp_pv0_drop", p0_valid, 0);

    // fresh reset so the first tie goes to p0; calib stays high
    i_rst = 1;
    tick();
    i_rst = 0;
    tick();

    for (int i = 0; i < 15; i++) begin
      p0_ren = vt[i].r0; p0_wen = vt[i].w0;
      p1_ren = vt[i].r1; p1_wen = vt[i].w1;
      dram_busy = vt[i].busy; dram_dv = vt[i].dv;
      #1;
      chk($sformatf("vec%0d_ack0", i), p0_ack, vt[i].a0);
      chk($sformatf("vec%0d_ack1", i), p1_ack, vt[i].a1);
      chk($sformatf("vec%0d_dren", i), dram_ren, vt[i].dren);
      chk($sformatf("vec%0d_dwen", i), dram_wen, vt[i].dwen);
      chk($sformatf("vec%0d_addr", i), dram_addr, vt[i].addr);
      chk($sformatf("vec%0d_mask", i), dram_mask, vt[i].mask);
      chk($sformatf("vec%0d_pv0", i), p0_valid, vt[i].pv0);
      chk($sformatf("vec%0d_pv1", i), p1_valid, vt[i].pv1);
      tick();
    end
    p0_ren = 0; p0_wen = 0; p1_ren = 0; p1_wen = 0; dram_busy = 0; dram_dv = 0;
    #1 chk("table_err", err, 0);
    tick();

    // routing of in-order responses
    p0_ren = 1; p0_addr = 27'h040;
    #1;
    chk("route_ack0", p0_ack, 1);
    chk("route_addr0", dram_addr, 27'h040);
    tick();
    p0_ren = 0; p1_ren = 1; p1_addr = 27'h080;
    #1;
    chk("route_ack1", p1_ack, 1);
    chk("route_addr1", dram_addr, 27'h080);
    tick();
    p1_ren = 0;
    dram_dv = 1; dram_rdata = LINE_A;
    #1 chk("route_pv0_early", p0_valid, 0);
    tick();
    dram_rdata = LINE_B;
    #1;
    chk("route_pv0", p0_valid, 1);
    chk("route_data0", p0_rdata, LINE_A);
    chk("route_pv1_early", p1_valid, 0);
    tick();
    dram_dv = 0;
    #1;
    chk("route_pv1", p1_valid, 1);
    chk("route_data1", p1_rdata, LINE_B);
    chk("route_pv0_drop", p0_valid, 0);
    chk("route_data0_hold", p0_rdata, LINE_A);
    tick();
    #1 chk("route_pv1_drop", p1_valid, 0);
    p0_addr = 27'h100; p1_addr = 27'h200;
    tick();

    // tag FIFO full
    p0_ren = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("full_ack%0d", i), p0_ack, 1);
      tick();
    end
    #1 chk("full_fifth_blocked", p0_ack, 0);
    dram_dv = 1; dram_rdata = LINE_D1;
    #1 chk("full_pop_same_cycle", p0_ack, 0);
    tick();
    dram_dv = 0;
    #1;
    chk("full_fifth_ack", p0_ack, 1);
    chk("full_pop_pv0", p0_valid, 1);
    tick();
    p0_ren = 0;
    dram_dv = 1;
    for (int i = 0; i < 4; i++) tick();
    dram_dv = 0;
    #1 chk("full_drain_pv0", p0_valid, 1);
    tick();
    #1 chk("full_err", err, 0);

    // response with nothing outstanding
    dram_dv = 1; dram_rdata = LINE_B;
    tick();
    dram_dv = 0;
    #1;
    chk("underflow_pv0", p0_valid, 0);
    chk("underflow_pv1", p1_valid, 0);
    chk("underflow_err", err, 1);
    tick();
    tick();
    tick();
    #1 chk("underflow_err_sticky", err, 1);

    // ren and wen together: read issued, write dropped, error flagged
    i_rst = 1;
    tick();
    i_rst = 0;
    #1;
    chk("rw_err_cleared", err, 0);
    chk("rw_wait_ack", p0_ack, 0);
    tick();
    p0_ren = 1; p0_wen = 1;
    #1;
    chk("rw_ack0", p0_ack, 1);
    chk("rw_dren", dram_ren, 1);
    chk("rw_dwen", dram_wen, 0);
    tick();
    p0_ren = 0; p0_wen = 0;
    #1 chk("rw_err", err, 1);

    // reset with a read outstanding: the late response is an error, not a strobe
    i_rst = 1;
    tick();
    i_rst = 0;
    #1 chk("midrst_err_clear", err, 0);
    tick();
    dram_dv = 1;
    tick();
    dram_dv = 0;
    #1;
    chk("midrst_pv0", p0_valid, 0);
    chk("midrst_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Two-requester arbiter sitting between the instruction-side and data-side cache controllers and the single DRAM user interface (128-bit line, ren/wen/addr/data/mask, data/valid/busy).
- Grants one single-beat command per cycle by round-robin.
- Tracks up to MAX_OUTSTANDING in-flight reads with an owner-tag FIFO.
- DRAM returns reads in issue order; each read response is steered back to the requester that issued it.
- Writes are posted and produce no response.

Parameters:
APP_ADDR_WIDTH, 28, DRAM app address width; line address ports are APP_ADDR_WIDTH-1 bits.
APP_DATA_WIDTH, 128, line width in bits.
APP_MASK_WIDTH, 16, byte-mask width; a mask bit of 1 means the byte is not written.
TAG_ADDR_WIDTH, 2, log2 of MAX_OUTSTANDING (maximum in-flight reads = 4).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_p0_ren, i_p1_ren  in  1  read request, held until ack
i_p0_wen, i_p1_wen  in  1  write request, held until ack; ren and wen both high on one port is illegal
i_p0_addr, i_p1_addr  in  APP_ADDR_WIDTH-1  line address, low 3 bits zero
i_p0_data, i_p1_data  in  APP_DATA_WIDTH  write line
i_p0_mask, i_p1_mask  in  APP_MASK_WIDTH  write byte mask
o_p0_ack, o_p1_ack  out  1  command accepted this cycle
o_p0_data, o_p1_data  out  APP_DATA_WIDTH  read line
o_p0_data_valid, o_p1_data_valid  out  1  one-cycle read-response strobe
o_dram_ren, o_dram_wen  out  1  command to DRAM
o_dram_addr  out  APP_ADDR_WIDTH-1  DRAM line address
o_dram_data  out  APP_DATA_WIDTH  DRAM write data
o_dram_mask  out  APP_MASK_WIDTH  DRAM byte mask
i_dram_data  in  APP_DATA_WIDTH  DRAM read data
i_dram_data_valid  in  1  DRAM read-data strobe
i_dram_busy  in  1  DRAM cannot accept a command
i_dram_calib_done  in  1  DRAM ready
o_err  out  1  sticky protocol error

Behaviour:
Interface:
- One clock (i_clk); reset i_rst is synchronous and active-high.

State machine (registered):
- WAIT_CALIB: no acks, no DRAM commands. Moves to RUN on the first cycle i_dram_calib_done is sampled high.
- RUN: stays in RUN until reset; calib deassertion is ignored.

Eligibility, all terms combinational:
- A port is eligible when it requests (ren|wen) AND state==RUN AND !i_dram_busy.
- A read additionally requires tag FIFO not full. Use the registered full flag; a pop in the same cycle does not free a slot.

Grant:
- If only one port is eligible, that port wins.
- If both are eligible, the port other than r_last wins.
- On any ack, r_last <= granted port. Reset value of r_last is 1, so p0 wins the first tie.

DRAM command path (combinational):
- o_dram_* = granted port's ren/wen/addr/data/mask, gated by grant.
- o_pN_ack = grant to port N.
- Acceptance is zero-latency: the command is issued to DRAM in the same cycle as the ack.

Tag FIFO:
- On an acked read, push the owner bit (0/1).
- On i_dram_data_valid, pop.
- Push and pop in the same cycle: occupancy unchanged.

Response path:
- One cycle after i_dram_data_valid, o_pN_data <= i_dram_data and o_pN_data_valid <= 1 for the popped owner only.
- Latency from DRAM valid to requester valid is exactly 1.
- o_pN_data holds its last value otherwise.

Errors (o_err, sticky until reset):
- i_dram_data_valid while the tag FIFO is empty: the data is dropped and o_err is set.
- ren&wen on an eligible port: the read is served, the write is ignored, and o_err is set.

Reset values:
- All outputs 0.
- State WAIT_CALIB, tag FIFO empty, o_err 0.

Reset mid-operation:
- Outstanding tags are discarded.
- Any later DRAM responses to pre-reset reads set o_err. The integrator must hold reset until DRAM is drained.

Decomposition:
- Shared package: state encodings (ARB_WAIT_CALIB=1'b0, ARB_RUN=1'b1) and port index constants PORT_IMEM=0 and PORT_DMEM=1.
- One sub-module: instantiate the existing SyncFIFO as the owner-tag FIFO, with DATA_WIDTH=1 and ADDR_WIDTH=TAG_ADDR_WIDTH.

Test Plan:
1. Calib gating: i_dram_calib_done=0 for 20 cycles with p0 read pending -> no ack and o_dram_ren=0. Raise calib -> ack exactly 1 cycle later.
2. Round-robin: both ports hold reads to 0x100/0x200 continuously -> acks alternate p0,p1,p0,p1. DRAM addrs 0x100,0x200,0x100,...
3. Routing: p0 reads 0x40, then p1 reads 0x80. DRAM returns lines A then B -> o_p0_data_valid with A, then o_p1_data_valid with B, each one cycle after the DRAM strobe.
4. Full: 4 reads acked with no response -> fifth read not acked. First response pops -> fifth read acked on the following cycle. A response in the same cycle as the fifth request does not allow an ack that cycle.
5. Busy/write: i_dram_busy=1 with p1 write pending -> no ack. Busy drops -> single ack, o_dram_wen=1, mask passed unchanged (e.g. 16'hFFF0), no response strobe.
6. Error: i_dram_data_valid with empty FIFO -> no response strobes, o_err=1 until i_rst.
